// File: rtl/wb_csr_slave_pkg.sv
// Shared ssdma CSR definitions for the Wishbone register slave:
// register byte offsets, CTRL/STATUS bit positions, FSM state
// encodings, termination codes and the byte-lane merge helper.
package wb_csr_slave_pkg;

    // Register byte offsets (address bits [7:2] select the word)
    localparam logic [7:0] CSR_CTRL_OFF   = 8'h00;
    localparam logic [7:0] CSR_STATUS_OFF = 8'h04;
    localparam logic [7:0] CSR_SRC_OFF    = 8'h08;
    localparam logic [7:0] CSR_DST_OFF    = 8'h0C;
    localparam logic [7:0] CSR_LEN_OFF    = 8'h10;
    localparam logic [7:0] CSR_ID_OFF     = 8'h14;

    // CTRL bit positions
    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_INT_EN_BIT = 1;

    // STATUS bit positions
    localparam int STATUS_DONE_BIT = 0;
    localparam int STATUS_BUSY_BIT = 1;

    // Bus-side FSM
    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } bus_state_e;

    // Transfer engine FSM
    typedef enum logic [1:0] {
        E_IDLE = 2'd0,
        E_RUN  = 2'd1,
        E_DONE = 2'd2
    } eng_state_e;

    // Cycle termination kind; one code means at most one termination line
    typedef enum logic [1:0] {
        TERM_NONE = 2'd0,
        TERM_ACK  = 2'd1,
        TERM_RTY  = 2'd2,
        TERM_ERR  = 2'd3
    } term_e;

    // Replace only the byte lanes whose select bit is set
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                res[i*8 +: 8] = new_val[i*8 +: 8];
            end else begin
                res[i*8 +: 8] = old_val[i*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_csr_slave_if.sv
// Wishbone slave-side bus bundle for the ssdma CSR block.
interface wb_csr_slave_if;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic [3:0]  wbs_sel_i;
    logic        wbs_we_i;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_cab_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o;
    logic        wbs_rty_o;
    logic        wbs_err_o;

    modport master (
        output wbs_adr_i, wbs_dat_i, wbs_sel_i, wbs_we_i,
               wbs_stb_i, wbs_cyc_i, wbs_cab_i,
        input  wbs_dat_o, wbs_ack_o, wbs_rty_o, wbs_err_o
    );

    modport slave (
        input  wbs_adr_i, wbs_dat_i, wbs_sel_i, wbs_we_i,
               wbs_stb_i, wbs_cyc_i, wbs_cab_i,
        output wbs_dat_o, wbs_ack_o, wbs_rty_o, wbs_err_o
    );
endinterface

// File: rtl/wb_csr_engine.sv
// Transfer engine: loads a countdown from LEN on start, counts down once
// per cycle and flags completion when the count has reached zero.
module wb_csr_engine
    import wb_csr_slave_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done_set
);

    eng_state_e       state_r;
    logic [LEN_W-1:0] cnt_r;

    // Engine FSM and countdown; start is only honoured when not running
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= E_IDLE;
            cnt_r   <= '0;
        end else begin
            case (state_r)
                E_IDLE, E_DONE: begin
                    if (start) begin
                        cnt_r   <= len;
                        state_r <= E_RUN;
                    end else begin
                        cnt_r   <= cnt_r;
                        state_r <= state_r;
                    end
                end
                E_RUN: begin
                    if (cnt_r == '0) begin
                        state_r <= E_DONE;
                    end else begin
                        cnt_r <= cnt_r - LEN_W'(1);
                    end
                end
                default: begin
                    state_r <= E_IDLE;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    // Status decodes of the state register; done_set lines up with the E_DONE entry edge
    assign busy     = (state_r == E_RUN);
    assign done_set = (state_r == E_RUN) && (cnt_r == '0);

endmodule

// File: rtl/wb_csr_slave.sv
// Wishbone CSR slave of the ssdma bridge: CTRL/STATUS/SRC/DST/LEN/ID
// registers, one registered termination per access followed by an idle
// cycle, retry of configuration writes while the engine is busy.
// Optional macro SSDMA_WB_ERR_EN: unmapped accesses and ID writes end with
// wbs_err_o; without it they are acknowledged, read 0 and are discarded.
module wb_csr_slave
    import wb_csr_slave_pkg::*;
#(
    parameter logic [31:0] ID_VALUE = 32'h55D0_0001,
    parameter int          LEN_W    = 16
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_n,
    wb_csr_slave_if.slave        wbs,
    output logic                 wb_int_o
);

    bus_state_e       bus_state_r;
    term_e            term_r;
    logic [31:0]      dat_r;
    logic             int_r;

    logic             int_en_r;
    logic             done_r;
    logic [31:0]      src_r;
    logic [31:0]      dst_r;
    logic [LEN_W-1:0] len_r;

    logic             req_s;
    logic [7:0]       word_off_s;
    logic             start_wr_s;
    logic             busy_s;
    logic             done_set_s;
    logic             start_s;
    term_e            term_s;
    logic [31:0]      rd_data_s;
    logic [31:0]      len_rd_s;
    logic             wr_ctrl_s;
    logic             wr_status_s;
    logic             wr_src_s;
    logic             wr_dst_s;
    logic             wr_len_s;
    logic             unused_s;

    assign req_s      = (bus_state_r == IDLE) && wbs.wbs_cyc_i && wbs.wbs_stb_i;
    assign word_off_s = {wbs.wbs_adr_i[7:2], 2'b00};
    assign start_wr_s = wbs.wbs_sel_i[0] && wbs.wbs_dat_i[CTRL_START_BIT];
    // Byte-offset bits, upper address bits and burst hint carry no meaning here
    assign unused_s   = ^{wbs.wbs_adr_i[31:8], wbs.wbs_adr_i[1:0], wbs.wbs_cab_i};

    // Zero-extend LEN to the bus width
    always_comb begin
        len_rd_s = 32'h0;
        len_rd_s[LEN_W-1:0] = len_r;
    end

    // Access decode: read data, termination kind and write strobes for a sampled request
    always_comb begin
        term_s      = TERM_NONE;
        rd_data_s   = 32'h0;
        wr_ctrl_s   = 1'b0;
        wr_status_s = 1'b0;
        wr_src_s    = 1'b0;
        wr_dst_s    = 1'b0;
        wr_len_s    = 1'b0;
        start_s     = 1'b0;
        if (req_s) begin
            case (word_off_s)
                CSR_CTRL_OFF: begin
                    rd_data_s[CTRL_INT_EN_BIT] = int_en_r;
                    if (wbs.wbs_we_i && start_wr_s && busy_s) begin
                        term_s = TERM_RTY;
                    end else begin
                        term_s    = TERM_ACK;
                        wr_ctrl_s = wbs.wbs_we_i;
                        start_s   = wbs.wbs_we_i && start_wr_s;
                    end
                end
                CSR_STATUS_OFF: begin
                    rd_data_s[STATUS_DONE_BIT] = done_r;
                    rd_data_s[STATUS_BUSY_BIT] = busy_s;
                    term_s      = TERM_ACK;
                    wr_status_s = wbs.wbs_we_i;
                end
                CSR_SRC_OFF: begin
                    rd_data_s = src_r;
                    if (wbs.wbs_we_i && busy_s) begin
                        term_s = TERM_RTY;
                    end else begin
                        term_s   = TERM_ACK;
                        wr_src_s = wbs.wbs_we_i;
                    end
                end
                CSR_DST_OFF: begin
                    rd_data_s = dst_r;
                    if (wbs.wbs_we_i && busy_s) begin
                        term_s = TERM_RTY;
                    end else begin
                        term_s   = TERM_ACK;
                        wr_dst_s = wbs.wbs_we_i;
                    end
                end
                CSR_LEN_OFF: begin
                    rd_data_s = len_rd_s;
                    if (wbs.wbs_we_i && busy_s) begin
                        term_s = TERM_RTY;
                    end else begin
                        term_s   = TERM_ACK;
                        wr_len_s = wbs.wbs_we_i;
                    end
                end
                CSR_ID_OFF: begin
                    rd_data_s = ID_VALUE;
`ifdef SSDMA_WB_ERR_EN
                    term_s = wbs.wbs_we_i ? TERM_ERR : TERM_ACK;
`else
                    term_s = TERM_ACK;
`endif
                end
                default: begin
                    rd_data_s = 32'h0;
`ifdef SSDMA_WB_ERR_EN
                    term_s = TERM_ERR;
`else
                    term_s = TERM_ACK;
`endif
                end
            endcase
        end else begin
            term_s = TERM_NONE;
        end
    end

    // Bus FSM: a request sampled in IDLE is terminated during the following RESP cycle
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            bus_state_r <= IDLE;
            term_r      <= TERM_NONE;
            dat_r       <= 32'h0;
        end else begin
            case (bus_state_r)
                IDLE: begin
                    if (req_s) begin
                        bus_state_r <= RESP;
                        term_r      <= term_s;
                        dat_r       <= (term_s == TERM_ACK) ? rd_data_s : 32'h0;
                    end else begin
                        bus_state_r <= IDLE;
                        term_r      <= TERM_NONE;
                        dat_r       <= 32'h0;
                    end
                end
                RESP: begin
                    bus_state_r <= IDLE;
                    term_r      <= TERM_NONE;
                    dat_r       <= 32'h0;
                end
                default: begin
                    bus_state_r <= IDLE;
                    term_r      <= TERM_NONE;
                    dat_r       <= 32'h0;
                end
            endcase
        end
    end

    // Register file and interrupt; hardware DONE set outranks a same-cycle clear
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            int_en_r <= 1'b0;
            done_r   <= 1'b0;
            src_r    <= 32'h0;
            dst_r    <= 32'h0;
            len_r    <= '0;
            int_r    <= 1'b0;
        end else begin
            if (wr_ctrl_s && wbs.wbs_sel_i[0]) begin
                int_en_r <= wbs.wbs_dat_i[CTRL_INT_EN_BIT];
            end
            if (wr_src_s) begin
                src_r <= merge_bytes(src_r, wbs.wbs_dat_i, wbs.wbs_sel_i);
            end
            if (wr_dst_s) begin
                dst_r <= merge_bytes(dst_r, wbs.wbs_dat_i, wbs.wbs_sel_i);
            end
            if (wr_len_s) begin
                len_r <= LEN_W'(merge_bytes(len_rd_s, wbs.wbs_dat_i, wbs.wbs_sel_i));
            end
            if (done_set_s) begin
                done_r <= 1'b1;
            end else if (start_s) begin
                done_r <= 1'b0;
            end else if (wr_status_s && wbs.wbs_sel_i[0] && wbs.wbs_dat_i[STATUS_DONE_BIT]) begin
                done_r <= 1'b0;
            end
            int_r <= done_r && int_en_r;
        end
    end

    wb_csr_engine #(
        .LEN_W (LEN_W)
    ) u_engine (
        .clk      (wb_clk_i),
        .rst_n    (wb_rst_n),
        .start    (start_s),
        .len      (len_r),
        .busy     (busy_s),
        .done_set (done_set_s)
    );

    // Outputs are masked by reset so a pending termination never escapes a reset cycle
    assign wbs.wbs_ack_o = wb_rst_n && (term_r == TERM_ACK);
    assign wbs.wbs_rty_o = wb_rst_n && (term_r == TERM_RTY);
`ifdef SSDMA_WB_ERR_EN
    assign wbs.wbs_err_o = wb_rst_n && (term_r == TERM_ERR);
`else
    assign wbs.wbs_err_o = 1'b0;
`endif
    assign wbs.wbs_dat_o = wb_rst_n ? dat_r : 32'h0;
    assign wb_int_o      = wb_rst_n && int_r;

endmodule
